// File: rtl/pte_read_responder_pkg.sv
// Shared PTE field positions, responder state encoding and A/D update helpers.
// The helpers are only referenced when PTE_AD_UPDATE_EN is defined.
package pte_read_responder_pkg;

  localparam int PTE_V      = 0;
  localparam int PTE_R      = 1;
  localparam int PTE_W      = 2;
  localparam int PTE_X      = 3;
  localparam int PTE_U      = 4;
  localparam int PTE_G      = 5;
  localparam int PTE_A      = 6;
  localparam int PTE_D      = 7;
  localparam int PTE_PPN_LO = 10;
  localparam int PTE_PPN_HI = 31;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ERR_ENC   = 3'd1;
  localparam logic [2:0] ST_GRANT_ENC = 3'd2;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd3;
  localparam logic [2:0] ST_RESP_ENC  = 3'd4;
  localparam logic [2:0] ST_UPD_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ERR   = ST_ERR_ENC,
    ST_GRANT = ST_GRANT_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_RESP  = ST_RESP_ENC,
    ST_UPD   = ST_UPD_ENC
  } pte_state_e;

  function automatic logic pte_is_leaf(input logic [31:0] pte);
    return pte[PTE_V] && (pte[PTE_R] || pte[PTE_X]);
  endfunction

  function automatic logic pte_needs_upd(input logic [31:0] pte, input logic store);
    return pte_is_leaf(pte) && (!pte[PTE_A] || (store && !pte[PTE_D]));
  endfunction

  function automatic logic [31:0] pte_ad_set(input logic [31:0] pte, input logic store);
    logic [31:0] r;
    r = pte;
    r[PTE_A] = 1'b1;
    if (store) r[PTE_D] = 1'b1;
    return r;
  endfunction

  // Non-leaf/permission fields are carried untouched; named here for MMU reuse.
  localparam logic [31:0] PTE_KEEP_MASK =
      (32'(1) << PTE_W) | (32'(1) << PTE_U) | (32'(1) << PTE_G) |
      ((32'(1) << (PTE_PPN_HI - PTE_PPN_LO + 1)) - 32'(1)) << PTE_PPN_LO;

endpackage

// File: rtl/pte_read_responder_lat.sv
// Loadable down-counter with a zero flag; used to time the RAM read latency.
module pte_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pte_read_responder.sv
// PTE read responder between the MMU walker and the shared data RAM port.
// Define PTE_AD_UPDATE_EN to write back A/D bits of leaf PTEs after the response.
//
// state | meaning
// IDLE  | ready for a walker request
// ERR   | one-cycle error response, no RAM access
// GRANT | waiting for the CPU to release the RAM port, then issue the read
// WAIT  | counting down RAM read latency, capture data at zero
// RESP  | one-cycle data response
// UPD   | A/D write-back of the leaf PTE (feature build only)
module pte_read_responder
  import pte_read_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        req_store,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        cpu_mem_active,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] LAT_LD = 2'(RD_LAT - 1);

  pte_state_e  r_state, w_state_nxt;
  logic [31:0] r_addr, r_rsp_data, w_off;
  logic        w_xfer, w_err, w_cnt_load, w_cnt_zero, w_capture, w_mem_sel, w_we;

  assign w_off  = req_addr - MEM_BASE;
  assign w_err  = (req_addr[1:0] != 2'b00) || (w_off >= MEM_SIZE);
  assign w_xfer = req_valid && (r_state == ST_IDLE);

`ifdef PTE_AD_UPDATE_EN
  logic r_store;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_store <= 1'b0;
    else if (w_xfer) r_store <= req_store;
  end
`else
  logic w_unused_store;
  assign w_unused_store = req_store;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_capture   = 1'b0;
    w_mem_sel   = 1'b0;
    w_we        = 1'b0;
    mem_re      = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = w_err ? ST_ERR : ST_GRANT;
      ST_ERR:   w_state_nxt = ST_IDLE;
      ST_GRANT: begin
        if (!cpu_mem_active) begin
          mem_re      = 1'b1;
          w_mem_sel   = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
`ifdef PTE_AD_UPDATE_EN
        if (pte_needs_upd(r_rsp_data, r_store)) w_state_nxt = ST_UPD;
`endif
      end
`ifdef PTE_AD_UPDATE_EN
      ST_UPD: begin
        if (!cpu_mem_active) begin
          w_we        = 1'b1;
          w_mem_sel   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_addr <= req_addr;
      // rsp_data only moves on the edge into a response state, so it holds otherwise
      if (w_xfer && w_err) r_rsp_data <= '0;
      else if (w_capture)  r_rsp_data <= mem_rdata;
    end
  end

  pte_lat_counter #(.W(2)) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LAT_LD),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_cnt_zero)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_ERR) || (r_state == ST_RESP);
  assign rsp_err   = (r_state == ST_ERR);
  assign rsp_data  = r_rsp_data;
  assign mem_addr  = w_mem_sel ? r_addr : 32'h0;

`ifdef PTE_AD_UPDATE_EN
  assign mem_we    = w_we;
  assign mem_wdata = w_we ? pte_ad_set(r_rsp_data, r_store) : 32'h0;
`else
  logic w_unused_we;
  assign w_unused_we = w_we;
  assign mem_we      = 1'b0;
  assign mem_wdata   = 32'h0;
`endif

endmodule
